// File: rtl/mem_bus_ctrl_pkg.sv
// Shared encodings for the M-stage bus controller: access sizes, FSM states
// and the load-extension types that ride along untouched to the extender.
package mem_bus_ctrl_pkg;

    typedef enum logic [1:0] {
        SIZE_W   = 2'b00,
        SIZE_H   = 2'b01,
        SIZE_B   = 2'b10,
        SIZE_RSV = 2'b11
    } reqSize_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } busState_t;

    typedef enum logic [2:0] {
        LD_LW  = 3'd0,
        LD_LH  = 3'd1,
        LD_LHU = 3'd2,
        LD_LB  = 3'd3,
        LD_LBU = 3'd4
    } ldType_t;

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// Pipeline request / bus / response bundle of the M-stage bus controller.
// master is the controller side, slave is the pipeline-plus-memory side.
interface mem_bus_ctrl_if;

    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_ldtype;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_byteen;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_ad;
    logic [2:0]  rsp_ldtype;
    logic        exc_adel;
    logic        exc_ades;
    logic        bus_err;

    modport master (
        input  req_valid, req_we, req_size, req_addr, req_wdata, req_ldtype,
        input  bus_ack, bus_rdata,
        output bus_req, bus_we, bus_addr, bus_byteen, bus_wdata,
        output stall, rsp_valid, rsp_rdata, rsp_ad, rsp_ldtype,
        output exc_adel, exc_ades, bus_err
    );

    modport slave (
        output req_valid, req_we, req_size, req_addr, req_wdata, req_ldtype,
        output bus_ack, bus_rdata,
        input  bus_req, bus_we, bus_addr, bus_byteen, bus_wdata,
        input  stall, rsp_valid, rsp_rdata, rsp_ad, rsp_ldtype,
        input  exc_adel, exc_ades, bus_err
    );

endinterface

// File: rtl/mem_bus_ctrl_store_lane_align.sv
// Store lane steering and alignment check: byte enables, replicated data, misaligned flag.
// Purely combinational, zero latency; no handshake, so no backpressure.
module mem_bus_ctrl_store_lane_align
    import mem_bus_ctrl_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addrLo,
    input  logic [31:0] wdata,
    output logic [3:0]  byteen,
    output logic [31:0] wdataRep,
    output logic        misaligned
);

    always_comb begin
        byteen     = 4'b0000;
        wdataRep   = 32'h0000_0000;
        misaligned = 1'b1;
        case (reqSize_t'(size))
            SIZE_W: begin
                byteen     = 4'b1111;
                wdataRep   = wdata;
                misaligned = (addrLo != 2'b00);
            end
            SIZE_H: begin
                byteen     = addrLo[1] ? 4'b1100 : 4'b0011;
                wdataRep   = {2{wdata[15:0]}};
                misaligned = addrLo[0];
            end
            SIZE_B: begin
                byteen     = 4'b0001 << addrLo;
                wdataRep   = {4{wdata[7:0]}};
                misaligned = 1'b0;
            end
            default: begin
                // reserved size: no lanes, always trapped as misaligned
                misaligned = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// M-stage bus controller: word-aligned bus cycles, pipeline stall, AdEL/AdES and watchdog abort.
// Latency: response N+1 cycles after acceptance for an ack N cycles into the bus cycle.
// Backpressure: stall holds the pipeline from acceptance until the bus acks or times out.
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic           clk,
    input  logic           reset,
    mem_bus_ctrl_if.master mb
);

    busState_t         state;
    busState_t         stateNxt;
    logic [CNT_W-1:0]  cnt;

    logic [31:0]       latAddr;
    logic              latWe;
    logic [3:0]        latByteen;
    logic [31:0]       latWdata;
    logic [2:0]        latLdtype;

    logic [31:0]       rspRdata;
    logic [1:0]        rspAd;
    logic [2:0]        rspLdtype;
    logic              excAdel;
    logic              excAdes;

    logic [3:0]        laneByteen;
    logic [31:0]       laneWdata;
    logic              laneMis;

    logic              accept;
    logic              complete;
    logic              timeoutHit;
    logic              busy;

    mem_bus_ctrl_store_lane_align uStoreLaneAlign (
        .size       (mb.req_size),
        .addrLo     (mb.req_addr[1:0]),
        .wdata      (mb.req_wdata),
        .byteen     (laneByteen),
        .wdataRep   (laneWdata),
        .misaligned (laneMis)
    );

    always_comb begin
        stateNxt   = state;
        accept     = 1'b0;
        complete   = 1'b0;
        timeoutHit = 1'b0;
        case (state)
            IDLE: begin
                if (mb.req_valid && !laneMis) begin
                    accept   = 1'b1;
                    stateNxt = BUSY;
                end
            end
            BUSY: begin
                // an ack on the last watchdog cycle still completes normally
                if (mb.bus_ack) begin
                    complete = 1'b1;
                    stateNxt = DONE;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    timeoutHit = 1'b1;
                    complete   = 1'b1;
                    stateNxt   = DONE;
                end
            end
            DONE: begin
                stateNxt = IDLE;
            end
            default: begin
                stateNxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            latAddr   <= 32'h0;
            latWe     <= 1'b0;
            latByteen <= 4'h0;
            latWdata  <= 32'h0;
            latLdtype <= 3'h0;
            rspRdata  <= 32'h0;
            rspAd     <= 2'h0;
            rspLdtype <= 3'h0;
            excAdel   <= 1'b0;
            excAdes   <= 1'b0;
        end else begin
            state   <= stateNxt;
            excAdel <= (state == IDLE) && mb.req_valid && laneMis && !mb.req_we;
            excAdes <= (state == IDLE) && mb.req_valid && laneMis &&  mb.req_we;

            if (accept) begin
                cnt       <= '0;
                latAddr   <= mb.req_addr;
                latWe     <= mb.req_we;
                latByteen <= mb.req_we ? laneByteen : 4'h0;
                latWdata  <= mb.req_we ? laneWdata : 32'h0;
                latLdtype <= mb.req_ldtype;
            end else if (state == BUSY) begin
                cnt <= cnt + CNT_W'(1);
            end

            // response fields only move on completion so the extender sees stable values
            if (complete) begin
                rspRdata  <= (mb.bus_ack && !latWe) ? mb.bus_rdata : 32'h0;
                rspAd     <= latAddr[1:0];
                rspLdtype <= latLdtype;
            end
        end
    end

    assign busy          = (state == BUSY);

    assign mb.bus_req    = busy;
    assign mb.bus_we     = busy & latWe;
    assign mb.bus_addr   = busy ? {latAddr[31:2], 2'b00} : 32'h0;
    assign mb.bus_byteen = busy ? latByteen : 4'h0;
    assign mb.bus_wdata  = busy ? latWdata : 32'h0;

    assign mb.stall      = accept | busy;
    assign mb.rsp_valid  = (state == DONE);
    assign mb.rsp_rdata  = rspRdata;
    assign mb.rsp_ad     = rspAd;
    assign mb.rsp_ldtype = rspLdtype;
    assign mb.exc_adel   = excAdel;
    assign mb.exc_ades   = excAdes;
    assign mb.bus_err    = timeoutHit;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: directed and random accesses against a cycle-level expectation model.
module tb_mem_bus_ctrl;
    import mem_bus_ctrl_pkg::*;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 5;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;
    logic [36:0] expRsp;

    mem_bus_ctrl_if mbIf ();

    mem_bus_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .mb    (mbIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [111:0] snap();
        return {mbIf.bus_req, mbIf.bus_we, mbIf.bus_addr, mbIf.bus_byteen, mbIf.bus_wdata,
                mbIf.stall, mbIf.bus_err, mbIf.rsp_valid, mbIf.exc_adel, mbIf.exc_ades,
                mbIf.rsp_rdata, mbIf.rsp_ad, mbIf.rsp_ldtype};
    endfunction

    function automatic logic [111:0] mkExp(logic req, logic we, logic [31:0] addr, logic [3:0] be,
                                           logic [31:0] wd, logic stl, logic err, logic rv,
                                           logic adel, logic ades);
        return {req, we, addr, be, wd, stl, err, rv, adel, ades, expRsp};
    endfunction

    // reference rules written as plain arithmetic on the byte address
    function automatic logic modelMis(logic [1:0] size, logic [31:0] addr);
        case (size)
            2'd0:    return (addr % 4) != 0;
            2'd1:    return (addr % 2) != 0;
            2'd2:    return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] modelBe(logic [1:0] size, logic [31:0] addr);
        case (size)
            2'd0:    return 4'hF;
            2'd1:    return ((addr % 4) >= 2) ? 4'hC : 4'h3;
            default: return 4'((1 << (addr % 4)) & 15);
        endcase
    endfunction

    function automatic logic [31:0] modelWd(logic [1:0] size, logic [31:0] wdata);
        case (size)
            2'd0:    return wdata;
            2'd1:    return (wdata & 32'hFFFF) * 32'h0001_0001;
            default: return (wdata & 32'hFF) * 32'h0101_0101;
        endcase
    endfunction

    // ackAt: BUSY cycle (1-based) carrying bus_ack, 0 = never acked
    task automatic do_access(input string name, input logic we, input logic [1:0] size,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [2:0] ldt, input int ackAt, input logic [31:0] rdata,
                             input bit tail);
        logic [111:0] got;
        logic [111:0] exp;
        logic [31:0]  eAddr;
        logic [3:0]   eBe;
        logic [31:0]  eWd;
        int           busyLen;
        @(posedge clk); #1;
        mbIf.req_valid  = 1'b1;
        mbIf.req_we     = we;
        mbIf.req_size   = size;
        mbIf.req_addr   = addr;
        mbIf.req_wdata  = wdata;
        mbIf.req_ldtype = ldt;
        mbIf.bus_rdata  = $urandom;
        if (modelMis(size, addr)) begin
            mbIf.bus_ack = 1'b0;
            @(negedge clk);
            vectors++; got = snap(); exp = mkExp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            if (got !== exp) begin miscompares++; $display("FAIL %s mis-req got=%h exp=%h", name, got, exp); end
            @(posedge clk); #1;
            mbIf.req_valid = 1'b0;
            @(negedge clk);
            vectors++; got = snap(); exp = mkExp(0, 0, 0, 0, 0, 0, 0, 0, !we, we);
            if (got !== exp) begin miscompares++; $display("FAIL %s exc-pulse got=%h exp=%h", name, got, exp); end
            @(posedge clk); #1;
            @(negedge clk);
            vectors++; got = snap(); exp = mkExp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            if (got !== exp) begin miscompares++; $display("FAIL %s exc-clear got=%h exp=%h", name, got, exp); end
            return;
        end
        mbIf.bus_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        vectors++; got = snap(); exp = mkExp(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        if (got !== exp) begin miscompares++; $display("FAIL %s accept got=%h exp=%h", name, got, exp); end

        eAddr   = addr - (addr % 4);
        eBe     = we ? modelBe(size, addr) : 4'h0;
        eWd     = we ? modelWd(size, wdata) : 32'h0;
        busyLen = (ackAt == 0) ? TIMEOUT : ackAt;
        for (int k = 1; k <= busyLen; k++) begin
            @(posedge clk); #1;
            mbIf.bus_ack    = (k == ackAt);
            mbIf.bus_rdata  = (k == ackAt) ? rdata : $urandom;
            mbIf.req_we     = 1'($urandom_range(0, 1));
            mbIf.req_size   = 2'($urandom_range(0, 3));
            mbIf.req_addr   = $urandom;
            mbIf.req_wdata  = $urandom;
            mbIf.req_ldtype = 3'($urandom_range(0, 7));
            @(negedge clk);
            vectors++; got = snap();
            exp = mkExp(1, we, eAddr, eBe, eWd, 1, (ackAt == 0) && (k == TIMEOUT), 0, 0, 0);
            if (got !== exp) begin miscompares++; $display("FAIL %s busy%0d got=%h exp=%h", name, k, got, exp); end
        end

        @(posedge clk); #1;
        mbIf.bus_ack = 1'b0;
        expRsp = {((ackAt != 0) && !we) ? rdata : 32'h0, addr[1:0], ldt};
        @(negedge clk);
        vectors++; got = snap(); exp = mkExp(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        if (got !== exp) begin miscompares++; $display("FAIL %s done got=%h exp=%h", name, got, exp); end

        if (tail) begin
            @(posedge clk); #1;
            mbIf.req_valid = 1'b0;
            mbIf.req_addr  = $urandom;
            @(negedge clk);
            vectors++; got = snap(); exp = mkExp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            if (got !== exp) begin miscompares++; $display("FAIL %s idle-hold got=%h exp=%h", name, got, exp); end
        end
    endtask

    task automatic test_reset();
        logic [111:0] got;
        reset          = 1'b0;
        mbIf.req_valid = 1'b0;
        mbIf.req_we    = 1'b0;
        mbIf.req_size  = SIZE_W;
        mbIf.req_addr  = 32'h0;
        mbIf.req_wdata = 32'h0;
        mbIf.req_ldtype = 3'h0;
        mbIf.bus_ack   = 1'b0;
        mbIf.bus_rdata = 32'h0;
        expRsp         = 37'h0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            mbIf.bus_ack   = 1'($urandom_range(0, 1));
            mbIf.bus_rdata = $urandom;
            @(negedge clk);
            vectors++; got = snap();
            if (got !== 112'h0) begin miscompares++; $display("FAIL reset%0d got=%h exp=0", i, got); end
        end
        @(posedge clk); #1;
        reset        = 1'b1;
        mbIf.bus_ack = 1'b0;
    endtask

    task automatic test_store_lanes();
        do_access("sw_1004", 1, SIZE_W, 32'h0000_1004, 32'hDEAD_BEEF, LD_LW, 2, 32'h0, 1);
        do_access("sb_2003", 1, SIZE_B, 32'h0000_2003, 32'h0000_00A5, LD_LB, 3, 32'h0, 1);
        do_access("sh_2002", 1, SIZE_H, 32'h0000_2002, 32'h0000_1234, LD_LH, 1, 32'h0, 1);
        do_access("sh_2000", 1, SIZE_H, 32'h0000_2000, 32'hFFFF_5678, LD_LH, 2, 32'h0, 1);
    endtask

    task automatic test_load();
        do_access("lh_3002", 0, SIZE_H, 32'h0000_3002, 32'h0, LD_LH, 1, 32'h8001_7FFF, 1);
        do_access("lbu_3001", 0, SIZE_B, 32'h0000_3001, 32'h0, LD_LBU, 4, 32'h1122_3344, 1);
    endtask

    task automatic test_misaligned();
        do_access("lw_3001", 0, SIZE_W, 32'h0000_3001, 32'h0, LD_LW, 1, 32'h0, 1);
        do_access("sh_3001", 1, SIZE_H, 32'h0000_3001, 32'h0, LD_LH, 1, 32'h0, 1);
        do_access("rsv_ld", 0, SIZE_RSV, 32'h0000_3000, 32'h0, LD_LW, 1, 32'h0, 1);
    endtask

    task automatic test_timeout();
        do_access("ld_timeout", 0, SIZE_W, 32'h0000_4000, 32'h0, LD_LW, 0, 32'hCAFE_F00D, 1);
        do_access("ld_ack_at_limit", 0, SIZE_W, 32'h0000_4004, 32'h0, LD_LW, TIMEOUT, 32'h5A5A_0FF0, 1);
    endtask

    task automatic test_reset_mid();
        logic [3:0]   got;
        logic [111:0] full;
        @(posedge clk); #1;
        mbIf.req_valid  = 1'b1;
        mbIf.req_we     = 1'b0;
        mbIf.req_size   = SIZE_W;
        mbIf.req_addr   = 32'h0000_4000;
        mbIf.req_ldtype = LD_LW;
        mbIf.bus_ack    = 1'b0;
        @(negedge clk);
        for (int k = 1; k <= 2; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            vectors++; got = {mbIf.bus_req, mbIf.stall, mbIf.rsp_valid, mbIf.bus_err};
            if (got !== 4'b1100) begin miscompares++; $display("FAIL rstmid busy%0d got=%b exp=1100", k, got); end
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset          = 1'b1;
        mbIf.req_valid = 1'b0;
        expRsp         = 37'h0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++; full = snap();
            if (full !== 112'h0) begin miscompares++; $display("FAIL rstmid after%0d got=%h exp=0", i, full); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        do_access("b2b_sw", 1, SIZE_W, 32'h0000_5000, 32'h0102_0304, LD_LW, 1, 32'h0, 0);
        do_access("b2b_lb", 0, SIZE_B, 32'h0000_5002, 32'h0, LD_LB, 2, 32'hA0B0_C0D0, 0);
        do_access("b2b_mis", 1, SIZE_W, 32'h0000_5006, 32'h0, LD_LW, 1, 32'h0, 0);
        do_access("b2b_lh", 0, SIZE_H, 32'h0000_5006, 32'h0, LD_LHU, 3, 32'h7766_5544, 1);
    endtask

    task automatic test_random();
        int ackAt;
        int r;
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      ackAt = 0;
            else if (r == 1) ackAt = TIMEOUT;
            else             ackAt = $urandom_range(1, 5);
            do_access($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      $urandom, $urandom, 3'($urandom_range(0, 7)), ackAt, $urandom,
                      1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_store_lanes();
        test_load();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        @(posedge clk); #1;
        mbIf.req_valid = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
- Memory-stage bus controller for the pipelined MIPS core, directly upstream of the load data extender.
- Turns each M-stage load/store into a word-aligned bus transaction with byte enables, and stalls the pipeline until the bus acknowledges.
- Returns the raw read word plus the latched address low bits and load type, so the downstream extender can select and extend the loaded value.
- Flags misaligned accesses (AdEL/AdES) without issuing a bus cycle, and aborts hung transactions with a watchdog.

Parameters:
TIMEOUT, 16, max cycles in BUSY waiting for bus_ack before abort (>=2)
CNT_W, 5, width of watchdog counter (must hold TIMEOUT)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-low reset
req_valid  in  1  M stage holds a memory instruction
req_we  in  1  1 store, 0 load
req_size  in  2  00 word, 01 half, 10 byte, 11 reserved
req_addr  in  32  byte address from ALU
req_wdata  in  32  store data (rt), value in low bits
req_ldtype  in  3  load extension type, passed through untouched
bus_req  out  1  transaction request
bus_we  out  1  write strobe
bus_addr  out  32  {req_addr[31:2],2'b00}
bus_byteen  out  4  byte enables, 0000 on loads
bus_wdata  out  32  lane-replicated store data
bus_ack  in  1  transaction complete
bus_rdata  in  32  read word, valid with bus_ack
stall  out  1  freeze F/D/E/M
rsp_valid  out  1  one-cycle pulse, response ready
rsp_rdata  out  32  raw captured read word
rsp_ad  out  2  req_addr[1:0] of the completed access
rsp_ldtype  out  3  req_ldtype of the completed access
exc_adel  out  1  one-cycle pulse, misaligned load
exc_ades  out  1  one-cycle pulse, misaligned store
bus_err  out  1  one-cycle pulse, watchdog abort

Behaviour:
- Reset (reset==0 at posedge): state=IDLE, counter=0, all outputs 0. Reset mid-transaction drops bus_req the next cycle; there is no response and no error.
- Misalignment rules:
  - word: addr[1:0]!=0
  - half: addr[0]!=0
  - byte: never
  - size 11: always misaligned
- Store lanes:
  - word: byteen 1111, data as-is
  - half: byteen addr[1]?1100:0011, data {2{wdata[15:0]}}
  - byte: byteen 4'b0001<<addr[1:0], data {4{wdata[7:0]}}
- States:
  - IDLE:
    - req_valid & misaligned: pulse exc_adel (load) or exc_ades (store) next cycle, stay IDLE, stall=0, no bus activity.
    - req_valid & aligned: latch addr/size/we/wdata/ldtype, go BUSY. stall=1 combinationally in this same cycle.
  - BUSY:
    - bus_req=1; bus_* are driven from latched registers and stay stable until ack. stall=1; counter increments each cycle.
    - bus_ack: capture bus_rdata (loads; 0 for stores) into rsp_rdata, go DONE.
    - counter reaches TIMEOUT-1 without ack: pulse bus_err, go DONE with rsp_rdata=0.
    - ack and timeout in the same cycle: ack wins, no bus_err.
  - DONE:
    - rsp_valid=1 and stall=0 for exactly one cycle; rsp_ad/rsp_ldtype come from the latch.
    - req_valid is ignored here: it is the same instruction, which advances at this edge. Next state IDLE.
- Latency:
  - aligned access with ack N cycles after bus_req rises (N>=1): stall is high N+1 cycles, rsp_valid comes N+1 cycles after acceptance.
  - bus_ack in the acceptance cycle (state IDLE) is ignored.
- Latched values feed the outputs; changes on req_* while in BUSY/DONE have no effect.
- rsp_rdata/rsp_ad/rsp_ldtype hold their last value until the next completion.

Decomposition:
- Shared package (macro.v): SIZE_W/H/B/RSV encodings, state encodings IDLE/BUSY/DONE, existing LdType constants (passed through unchanged).
- One combinational sub-module, store_lane_align: inputs size, addr[1:0], wdata; outputs byteen, wdata_rep, misaligned.
- The FSM, latches and watchdog stay in mem_bus_ctrl.

Test Plan:
- Directed scenarios:
  - SW addr 0x1004 wdata 0xDEADBEEF, ack 2 cycles after bus_req -> bus_addr 0x1004, byteen 1111, stall high 3 cycles, rsp_valid one pulse.
  - SB addr 0x2003 wdata 0x000000A5 -> byteen 1000, bus_wdata 0xA5A5A5A5.
  - SH addr 0x2002 wdata 0x1234 -> byteen 1100, bus_wdata 0x12341234.
  - LH addr 0x3002, bus_rdata 0x8001_7FFF, ack 1 cycle -> rsp_rdata 0x80017FFF, rsp_ad 2'b10, rsp_ldtype echoed, byteen 0000, bus_we 0.
  - LW addr 0x3001 -> exc_adel pulse, bus_req never asserts, stall 0. SH addr 0x3001 -> exc_ades pulse, bus_req never asserts.
  - Load with no ack, TIMEOUT=16 -> bus_err pulse after 16 BUSY cycles, then rsp_valid with rsp_rdata 0.
  - Same load, reset low in 3rd BUSY cycle -> bus_req 0 next cycle, no rsp_valid, no bus_err.
